pc_fetch_controller: RTL and testbench
======================================

# pc_fetch_controller

Sequencing controller for the Program_Counter and the IF/ID, ID/EX and EX/MEM pipeline registers of the pipelined CPU. Every cycle it decides among three actions: advance the PC by 4, freeze it, or redirect it to a resolved branch target. It covers load-use stalls, a multi-cycle multiply/divide unit (MDU) and branch flushes. It also keeps saturating performance counters for stall cycles and flush events.

## Interface
- MDU_LAT, default 4: total stall cycles for one MDU operation; legal range 2..255.
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_i  input  32  current PC, taken from the Program_Counter output.
- load_use_i  input  1  load-use hazard detected in ID.
- mdu_start_i  input  1  MDU instruction entering EX this cycle.
- branch_taken_i  input  1  branch/jump resolved taken in MEM.
- branch_target_i  input  32  redirect address, valid when branch_taken_i=1.
- pc_next_o  output  32  next-PC value, driven to the PC input.
- pc_write_o  output  1  PC write enable, driven to PCWrite.
- ifid_write_o  output  1  IF/ID register write enable.
- idex_write_o  output  1  ID/EX register write enable.
- ifid_flush_o, idex_flush_o, exmem_flush_o  output  1 each  insert a bubble into that register.
- mdu_abort_o  output  1  kill the in-flight MDU operation.
- busy_o  output  1  high while in state MDU_BUSY.
- stall_cycles_o  output  16  saturating count of cycles with pc_write_o=0.
- flush_events_o  output  16  saturating count of cycles with branch_taken_i=1.

## Operation
- State machine: RUN (2'b00) and MDU_BUSY (2'b01). Counter cnt is 8 bits wide.
- Outputs are combinational from the state and inputs, and are evaluated in priority order.
- **Priority 1, branch_taken_i=1 (any state):**
  - pc_next_o=branch_target_i, pc_write_o=1, ifid_write_o=1, idex_write_o=1.
  - ifid_flush_o=1, idex_flush_o=1, exmem_flush_o=1.
  - If the state is MDU_BUSY: mdu_abort_o=1.
  - Next state is RUN and cnt is cleared to 0.
  - A simultaneous load_use_i or mdu_start_i is ignored.
- **Priority 2, RUN with mdu_start_i=1:**
  - pc_next_o=pc_i; pc_write_o, ifid_write_o and idex_write_o all 0.
  - exmem_flush_o=1.
  - cnt is loaded with MDU_LAT-1 and the next state is MDU_BUSY.
  - mdu_start_i wins over a simultaneous load_use_i.
- **Priority 3, RUN with load_use_i=1:**
  - pc_next_o=pc_i; pc_write_o=0, ifid_write_o=0, idex_write_o=1.
  - idex_flush_o=1 (one bubble). The state stays RUN.
- **Priority 4, MDU_BUSY without a branch:**
  - Same outputs as priority 2: PC, IF/ID and ID/EX frozen, exmem_flush_o=1.
  - cnt decrements by 1 each cycle.
  - When cnt==1 the next state is RUN; the counter reaches 0 on that edge.
  - load_use_i and mdu_start_i are ignored.
- **Default, RUN with no request:**
  - pc_next_o=pc_i+32'd4, with modulo-2^32 wrap (0xFFFFFFFC -> 0x00000000).
  - All write enables 1; all flushes 0.
- Any output not named in a case above is 0 in that case.
- busy_o = (state==MDU_BUSY).
- **stall_cycles_o:** +1 on every edge where pc_write_o=0; holds at 0xFFFF.
- **flush_events_o:** +1 on every edge where branch_taken_i=1; holds at 0xFFFF.

## Timing
- **Reset (asynchronous):** state=RUN, cnt=0, both counters 0.
- **While rst_n=0:**
  - pc_next_o=0.
  - All write enables are forced to 0 and all three flush outputs to 1.
  - mdu_abort_o=0 and busy_o=0.
- **Reset release:** the first edge with rst_n=1 follows the normal rules.
- **Reset mid-MDU:** aborts the sequence. No mdu_abort_o pulse; the MDU is reset by the same rst_n.
- **MDU stall:** exactly MDU_LAT consecutive cycles with pc_write_o=0. That is the start cycle plus MDU_LAT-1 cycles in MDU_BUSY. pc_write_o returns to 1 in the cycle after the last busy cycle.
- **Load-use stall:** exactly 1 cycle per cycle load_use_i is asserted. Back-to-back assertions give back-to-back stalls.
- **Branch redirect:** zero-latency; the PC takes branch_target_i on the same edge.
- **Counter updates:** both counters are visible the cycle after the qualifying event.

## Test plan
- **Sequential fetch:** reset, release, hold pc_i to follow pc_next_o for 5 cycles from 0 -> pc_next_o is 4, 8, 12, 16, 20; stall_cycles_o=0. With pc_i=0xFFFFFFFC, pc_next_o=0.
- **Load-use:** pc_i=0x20, load_use_i pulsed for 1 cycle -> that cycle pc_write_o=0, ifid_write_o=0, idex_flush_o=1. Next cycle pc_next_o=0x24. stall_cycles_o=1.
- **MDU, MDU_LAT=4:** mdu_start_i pulsed at cycle t -> pc_write_o=0 for cycles t..t+3 and busy_o=1 for t+1..t+3. exmem_flush_o=1 throughout. pc_write_o=1 at t+4. stall_cycles_o=4.
- **Branch during MDU_BUSY:** at the second busy cycle assert branch_taken_i with target 0x100 -> same cycle: pc_next_o=0x100, pc_write_o=1, all three flushes 1, mdu_abort_o=1. Next cycle busy_o=0. flush_events_o=1.
- **Simultaneous requests in RUN:** branch_taken_i with load_use_i -> branch wins, no stall. mdu_start_i with load_use_i -> MDU sequence of MDU_LAT cycles only.
- **Reset mid-operation and saturation:**
  - Drop rst_n during MDU_BUSY -> flushes=1, write enables=0, busy_o=0 immediately. After release, fetch resumes at RUN with both counters 0.
  - Hold load_use_i for 70000 cycles -> stall_cycles_o=0xFFFF.

Source files
------------

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
//   Sequences the Program_Counter and the IF/ID, ID/EX and EX/MEM pipeline
//   registers. Each cycle it chooses between PC+4, a freeze, or a redirect
//   to a resolved branch target. It also keeps saturating stall/flush
//   performance counters.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_n            asynchronous active-low reset
//   pc_i             current PC from the Program_Counter
//   load_use_i       load-use hazard detected in ID
//   mdu_start_i      MDU instruction entering EX this cycle
//   branch_taken_i   branch/jump resolved taken in MEM
//   branch_target_i  redirect address, valid with branch_taken_i
//   pc_next_o        next-PC value to the PC input
//   pc_write_o       PC write enable
//   ifid_write_o     IF/ID write enable
//   idex_write_o     ID/EX write enable
//   ifid_flush_o     bubble into IF/ID
//   idex_flush_o     bubble into ID/EX
//   exmem_flush_o    bubble into EX/MEM
//   mdu_abort_o      kill the in-flight MDU operation
//   busy_o           high while an MDU operation holds the pipe
//   stall_cycles_o   saturating count of cycles with pc_write_o=0
//   flush_events_o   saturating count of cycles with branch_taken_i=1
//
// The pipeline controls are combinational from state and inputs because
// the PC and pipeline registers consume them in the same cycle.

module pc_fetch_controller #(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        load_use_i,
  input  logic        mdu_start_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_next_o,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        idex_write_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        exmem_flush_o,
  output logic        mdu_abort_o,
  output logic        busy_o,
  output logic [15:0] stall_cycles_o,
  output logic [15:0] flush_events_o
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PERF_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MDU_BUSY = 2'b01
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  stall_q, stall_d;
  logic [PERF_W-1:0]  flush_q, flush_d;

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Next-state and pipeline control, evaluated in priority order
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_next_o     = '0;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    idex_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    mdu_abort_o   = 1'b0;
    busy_o        = (state_q == MDU_BUSY);

    if (branch_taken_i) begin
      pc_next_o     = branch_target_i;
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      idex_write_o  = 1'b1;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      mdu_abort_o   = (state_q == MDU_BUSY);
      state_d       = RUN;
      cnt_d         = '0;
    end else if (state_q == MDU_BUSY) begin
      pc_next_o     = pc_i;
      exmem_flush_o = 1'b1;
      cnt_d         = cnt_q - CNT_W'(1);
      // Leave on cnt==1; <=1 also recovers from an impossible cnt==0.
      if (cnt_q <= CNT_W'(1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else if (mdu_start_i) begin
      pc_next_o     = pc_i;
      exmem_flush_o = 1'b1;
      cnt_d         = CNT_W'(MDU_LAT - 1);
      state_d       = MDU_BUSY;
    end else if (load_use_i) begin
      pc_next_o     = pc_i;
      idex_write_o  = 1'b1;
      idex_flush_o  = 1'b1;
      state_d       = RUN;
    end else begin
      pc_next_o     = pc_i + 32'd4;
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      idex_write_o  = 1'b1;
      state_d       = RUN;
    end

    // Hold the pipeline in bubbles while reset is asserted
    if (!rst_n) begin
      pc_next_o     = '0;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      mdu_abort_o   = 1'b0;
      busy_o        = 1'b0;
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write_o && (stall_q != '1)) begin
      stall_d = stall_q + PERF_W'(1);
    end
    if (branch_taken_i && (flush_q != '1)) begin
      flush_d = flush_q + PERF_W'(1);
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller (MDU_LAT=4). Inputs change just
// after the falling edge and outputs are sampled 1ns later.

module tb_pc_fetch_controller;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        load_use_i;
  logic        mdu_start_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_next_o;
  logic        pc_write_o, ifid_write_o, idex_write_o;
  logic        ifid_flush_o, idex_flush_o, exmem_flush_o;
  logic        mdu_abort_o, busy_o;
  logic [15:0] stall_cycles_o, flush_events_o;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_controller #(.MDU_LAT(4)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .pc_i(pc_i),
    .load_use_i(load_use_i), .mdu_start_i(mdu_start_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .pc_next_o(pc_next_o), .pc_write_o(pc_write_o),
    .ifid_write_o(ifid_write_o), .idex_write_o(idex_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
    .exmem_flush_o(exmem_flush_o), .mdu_abort_o(mdu_abort_o),
    .busy_o(busy_o), .stall_cycles_o(stall_cycles_o),
    .flush_events_o(flush_events_o)
  );

  always #5 clk_i = ~clk_i;

  // {pcw, ifidw, idexw, ifidf, idexf, exmemf, abort, busy}
  function automatic logic [7:0] flags();
    return {pc_write_o, ifid_write_o, idex_write_o, ifid_flush_o,
            idex_flush_o, exmem_flush_o, mdu_abort_o, busy_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic lu, input logic ms,
                       input logic bt, input logic [31:0] tgt);
    @(negedge clk_i);
    pc_i            = pc;
    load_use_i      = lu;
    mdu_start_i     = ms;
    branch_taken_i  = bt;
    branch_target_i = tgt;
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        lu;
    logic        ms;
    logic        bt;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic [7:0]  exp_fl;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] cur;

    // Cycle-by-cycle sequence starting in RUN with both counters at 0
    vecs[0]  = '{32'h20, 1'b1, 1'b0, 1'b0, 32'h0,  32'h20, 8'b0010_1000}; // load-use
    vecs[1]  = '{32'h20, 1'b0, 1'b0, 1'b0, 32'h0,  32'h24, 8'b1110_0000};
    vecs[2]  = '{32'h40, 1'b1, 1'b0, 1'b1, 32'h80, 32'h80, 8'b1111_1100}; // branch beats load-use
    vecs[3]  = '{32'h80, 1'b1, 1'b1, 1'b0, 32'h0,  32'h80, 8'b0000_0100}; // mdu beats load-use
    vecs[4]  = '{32'h80, 1'b1, 1'b0, 1'b0, 32'h0,  32'h80, 8'b0000_0101}; // busy, lu ignored
    vecs[5]  = '{32'h80, 1'b0, 1'b1, 1'b0, 32'h0,  32'h80, 8'b0000_0101}; // busy, ms ignored
    vecs[6]  = '{32'h80, 1'b0, 1'b0, 1'b0, 32'h0,  32'h80, 8'b0000_0101}; // last busy
    vecs[7]  = '{32'h80, 1'b0, 1'b0, 1'b0, 32'h0,  32'h84, 8'b1110_0000}; // resumes
    vecs[8]  = '{32'h84, 1'b1, 1'b0, 1'b0, 32'h0,  32'h84, 8'b0010_1000};
    vecs[9]  = '{32'h84, 1'b1, 1'b0, 1'b0, 32'h0,  32'h84, 8'b0010_1000};
    vecs[10] = '{32'h84, 1'b0, 1'b0, 1'b0, 32'h0,  32'h88, 8'b1110_0000};

    // Reset state
    rst_n = 1'b0;
    drive(32'h1234, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_pc_next", pc_next_o, 32'h0);
    chk("rst_flags", 32'(flags()), 32'(8'b0001_1100));
    chk("rst_stall", 32'(stall_cycles_o), 32'h0);
    chk("rst_flush", 32'(flush_events_o), 32'h0);

    // Sequential fetch from 0
    rst_n = 1'b1;
    cur = 32'h0;
    for (int i = 0; i < 5; i++) begin
      drive(cur, 1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("seq_pc_next_%0d", i), pc_next_o, cur + 32'd4);
      chk($sformatf("seq_flags_%0d", i), 32'(flags()), 32'(8'b1110_0000));
      cur = cur + 32'd4;
    end
    chk("seq_stall", 32'(stall_cycles_o), 32'h0);
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc_next", pc_next_o, 32'h0);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].pc, vecs[i].lu, vecs[i].ms, vecs[i].bt, vecs[i].tgt);
      chk($sformatf("vec%0d_pc_next", i), pc_next_o, vecs[i].exp_pc);
      chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].exp_fl));
    end
    // 1 load-use + 4 MDU + 2 load-use stalls, 1 branch
    chk("tbl_stall", 32'(stall_cycles_o), 32'd7);
    chk("tbl_flush", 32'(flush_events_o), 32'd1);

    // Branch during the second MDU_BUSY cycle
    drive(32'h90, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("bb_start_busy", 32'(busy_o), 32'h0);
    drive(32'h90, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("bb_busy1", 32'(busy_o), 32'h1);
    drive(32'h90, 1'b0, 1'b0, 1'b1, 32'h100);
    chk("bb_pc_next", pc_next_o, 32'h100);
    chk("bb_flags", 32'(flags()), 32'(8'b1111_1111));
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("bb_after_busy", 32'(busy_o), 32'h0);
    chk("bb_after_pc_next", pc_next_o, 32'h104);
    chk("bb_after_abort", 32'(mdu_abort_o), 32'h0);
    chk("bb_flush", 32'(flush_events_o), 32'd2);
    chk("bb_stall", 32'(stall_cycles_o), 32'd9);

    // Reset dropped in MDU_BUSY
    drive(32'h180, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(32'h180, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rm_busy_before", 32'(busy_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rm_flags", 32'(flags()), 32'(8'b0001_1100));
    chk("rm_pc_next", pc_next_o, 32'h0);
    chk("rm_stall", 32'(stall_cycles_o), 32'h0);
    chk("rm_flush", 32'(flush_events_o), 32'h0);
    @(negedge clk_i);
    rst_n = 1'b1;
    drive(32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rm_resume_pc_next", pc_next_o, 32'h204);
    chk("rm_resume_flags", 32'(flags()), 32'(8'b1110_0000));
    chk("rm_resume_stall", 32'(stall_cycles_o), 32'h0);
    drive(32'h204, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rm_resume_busy", 32'(busy_o), 32'h0);

    // Stall counter saturation
    drive(32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (70000) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("sat_stall", 32'(stall_cycles_o), 32'h0000_FFFF);
    chk("sat_flags", 32'(flags()), 32'(8'b0010_1000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
